logs_square_voice: RTL and testbench

Programmable square-wave voice generator that produces one 1-bit audio line for the downstream population-count PWM mixer. It accepts note commands (half-period, duration) over a valid/ready handshake and buffers one queued command while the current note plays. It times note durations from an external tick strobe, inserts a fixed silent gap between notes, and pulses a completion flag. N instances feed the mixer's N audio inputs.

---
 rtl/logs_square_voice.sv | 128 ++++++++++++
 tb/tb_logs_square_voice.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/logs_square_voice.sv
// Square-wave voice: one-deep command queue, tick-timed note lengths and a
// fixed silent gap between notes, driving one 1-bit line into the PWM mixer.
module logs_square_voice #(
  parameter int PW        = 16,
  parameter int LW        = 8,
  parameter int GAP_TICKS = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [PW-1:0] cmd_period,
  input  logic [LW-1:0] cmd_len,
  output logic          audio_out,
  output logic          busy,
  output logic          note_done
);

  localparam int GW = (GAP_TICKS < 1) ? 1 : $clog2(GAP_TICKS + 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t        state, state_next;
  logic          pend_valid, pend_valid_next;
  logic [PW-1:0] pend_period, pend_period_next;
  logic [LW-1:0] pend_len, pend_len_next;
  logic [PW-1:0] act_period, act_period_next;
  logic [PW-1:0] phase, phase_next;
  logic [LW-1:0] remaining, remaining_next;
  logic [GW-1:0] gap_cnt, gap_cnt_next;
  logic          audio_next;
  logic          note_done_next;

  assign cmd_ready = !pend_valid && !reset;
  assign busy      = (state != IDLE) || pend_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pend_valid  <= 1'b0;
      pend_period <= '0;
      pend_len    <= '0;
      act_period  <= '0;
      phase       <= '0;
      remaining   <= '0;
      gap_cnt     <= '0;
      audio_out   <= 1'b0;
      note_done   <= 1'b0;
    end else begin
      state       <= state_next;
      pend_valid  <= pend_valid_next;
      pend_period <= pend_period_next;
      pend_len    <= pend_len_next;
      act_period  <= act_period_next;
      phase       <= phase_next;
      remaining   <= remaining_next;
      gap_cnt     <= gap_cnt_next;
      audio_out   <= audio_next;
      note_done   <= note_done_next;
    end
  end

  // Accept and IDLE-load never collide: accept needs pending empty, load needs it full.
  always_comb begin
    state_next       = state;
    pend_valid_next  = pend_valid;
    pend_period_next = pend_period;
    pend_len_next    = pend_len;
    act_period_next  = act_period;
    phase_next       = phase;
    remaining_next   = remaining;
    gap_cnt_next     = gap_cnt;
    audio_next       = audio_out;
    note_done_next   = 1'b0;

    if (cmd_valid && cmd_ready) begin
      pend_valid_next  = 1'b1;
      pend_period_next = cmd_period;
      pend_len_next    = cmd_len;
    end

    case (state)
      IDLE: begin
        audio_next = 1'b0;
        if (pend_valid) begin
          pend_valid_next = 1'b0;
          act_period_next = pend_period;
          remaining_next  = (pend_len == '0) ? LW'(1) : pend_len;
          phase_next      = '0;
          state_next      = PLAY;
        end
      end
      PLAY: begin
        // A note-ending tick overrides any phase toggle on the same edge.
        if (tick && remaining == LW'(1)) begin
          note_done_next = 1'b1;
          audio_next     = 1'b0;
          if (GAP_TICKS > 0) begin
            gap_cnt_next = GW'(GAP_TICKS);
            state_next   = GAP;
          end else begin
            state_next = IDLE;
          end
        end else begin
          if (tick) remaining_next = remaining - LW'(1);
          if (act_period == '0) begin
            audio_next = 1'b0;
          end else if (phase == act_period) begin
            phase_next = '0;
            audio_next = !audio_out;
          end else begin
            phase_next = phase + PW'(1);
          end
        end
      end
      GAP: begin
        audio_next = 1'b0;
        if (tick) begin
          gap_cnt_next = gap_cnt - GW'(1);
          if (gap_cnt == GW'(1)) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_logs_square_voice.sv
// Directed self-checking bench for logs_square_voice (PW=16, LW=8, GAP_TICKS=1).
module tb_logs_square_voice;

  logic        clk = 1'b0;
  logic        reset, tick, cmd_valid;
  logic        cmd_ready, audio_out, busy, note_done;
  logic [15:0] cmd_period;
  logic [7:0]  cmd_len;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  logs_square_voice #(.PW(16), .LW(8), .GAP_TICKS(1)) dut (
    .clk(clk), .reset(reset), .tick(tick), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_period(cmd_period), .cmd_len(cmd_len),
    .audio_out(audio_out), .busy(busy), .note_done(note_done)
  );

  // Advance one edge and settle; all sampling happens 1 time unit after posedge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b0; cmd_valid = 1'b0; cmd_period = '0; cmd_len = '0;
    repeat (3) cycle();
    checks++; if (audio_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_audio got %b want 0", audio_out); end
    checks++; if (note_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", note_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b want 0", cmd_ready); end
    reset = 1'b0;
    cycle();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL release_busy got %b want 0", busy); end
  endtask

  task automatic test_tone();
    logic exp_audio;
    cmd_valid = 1'b1; cmd_period = 16'd3; cmd_len = 8'd2;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL tone_ready got %b want 1", cmd_ready); end
    cycle();
    cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL tone_ready_after got %b want 0", cmd_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL tone_busy_pend got %b want 1", busy); end
    cycle();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL tone_ready_load got %b want 1", cmd_ready); end
    checks++; if (audio_out !== 1'b0) begin errors++; $display("[TB] FAIL tone_audio_entry got %b want 0", audio_out); end
    for (int k = 1; k <= 24; k++) begin
      tick = (k == 13 || k == 22);
      cycle();
      tick = 1'b0;
      exp_audio = (k < 22) ? 1'(((k / 4) % 2)) : 1'b0;
      checks++; if (audio_out !== exp_audio) begin errors++; $display("[TB] FAIL tone_audio k=%0d got %b want %b", k, audio_out, exp_audio); end
      checks++; if (note_done !== (k == 22)) begin errors++; $display("[TB] FAIL tone_done k=%0d got %b want %b", k, note_done, (k == 22)); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL tone_busy_gap got %b want 1", busy); end
    tick = 1'b1; cycle(); tick = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL tone_busy_end got %b want 0", busy); end
    checks++; if (audio_out !== 1'b0) begin errors++; $display("[TB] FAIL tone_audio_end got %b want 0", audio_out); end
  endtask

  task automatic test_rest();
    int done_count;
    done_count = 0;
    cmd_valid = 1'b1; cmd_period = 16'd0; cmd_len = 8'd3;
    cycle();
    cmd_valid = 1'b0;
    cycle();
    for (int k = 1; k <= 9; k++) begin
      tick = (k % 3 == 0);
      cycle();
      tick = 1'b0;
      checks++; if (audio_out !== 1'b0) begin errors++; $display("[TB] FAIL rest_audio k=%0d got %b want 0", k, audio_out); end
      if (note_done === 1'b1) done_count++;
      if (k == 8) begin
        checks++; if (done_count != 0) begin errors++; $display("[TB] FAIL rest_early_done got %0d want 0", done_count); end
      end
    end
    checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL rest_done_count got %0d want 1", done_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rest_busy_gap got %b want 1", busy); end
    tick = 1'b1; cycle(); tick = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rest_busy_end got %b want 0", busy); end
  endtask

  task automatic test_len_zero_one();
    logic exp_audio;
    for (int i = 0; i < 2; i++) begin
      cmd_valid = 1'b1; cmd_period = 16'd2; cmd_len = 8'(i);
      cycle();
      cmd_valid = 1'b0;
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL len%0d_busy_load got %b want 1", i, busy); end
      for (int k = 1; k <= 5; k++) begin
        tick = (k == 5);
        cycle();
        tick = 1'b0;
        exp_audio = (k < 5) ? 1'(((k / 3) % 2)) : 1'b0;
        checks++; if (audio_out !== exp_audio) begin errors++; $display("[TB] FAIL len%0d_audio k=%0d got %b want %b", i, k, audio_out, exp_audio); end
        checks++; if (note_done !== (k == 5)) begin errors++; $display("[TB] FAIL len%0d_done k=%0d got %b want %b", i, k, note_done, (k == 5)); end
      end
      tick = 1'b1; cycle(); tick = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL len%0d_busy_end got %b want 0", i, busy); end
    end
  endtask

  task automatic test_back_to_back();
    // Note A: period 1, len 1
    cmd_valid = 1'b1; cmd_period = 16'd1; cmd_len = 8'd1;
    cycle();
    cmd_valid = 1'b0;
    cycle();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL q_ready_a got %b want 1", cmd_ready); end
    // Note B queued while A plays
    cmd_valid = 1'b1; cmd_period = 16'd2; cmd_len = 8'd1;
    cycle();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL q_ready_b got %b want 0", cmd_ready); end
    // Note C presented and must stall
    cmd_period = 16'd3; cmd_len = 8'd1;
    cycle();
    checks++; if (audio_out !== 1'b1) begin errors++; $display("[TB] FAIL q_a_audio got %b want 1", audio_out); end
    tick = 1'b1; cycle(); tick = 1'b0;
    checks++; if (note_done !== 1'b1) begin errors++; $display("[TB] FAIL q_a_done got %b want 1", note_done); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL q_stall_gap got %b want 0", cmd_ready); end
    tick = 1'b1; cycle(); tick = 1'b0;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL q_stall_idle got %b want 0", cmd_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL q_busy_idle got %b want 1", busy); end
    cycle();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL q_ready_c got %b want 1", cmd_ready); end
    cycle();
    cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL q_c_taken got %b want 0", cmd_ready); end
    cycle();
    checks++; if (audio_out !== 1'b0) begin errors++; $display("[TB] FAIL q_b_audio2 got %b want 0", audio_out); end
    cycle();
    checks++; if (audio_out !== 1'b1) begin errors++; $display("[TB] FAIL q_b_audio3 got %b want 1", audio_out); end
    tick = 1'b1; cycle(); tick = 1'b0;
    checks++; if (note_done !== 1'b1) begin errors++; $display("[TB] FAIL q_b_done got %b want 1", note_done); end
    tick = 1'b1; cycle(); tick = 1'b0;
    cycle();
    repeat (3) cycle();
    checks++; if (audio_out !== 1'b0) begin errors++; $display("[TB] FAIL q_c_audio3 got %b want 0", audio_out); end
    cycle();
    checks++; if (audio_out !== 1'b1) begin errors++; $display("[TB] FAIL q_c_audio4 got %b want 1", audio_out); end
    tick = 1'b1; cycle(); tick = 1'b0;
    checks++; if (note_done !== 1'b1) begin errors++; $display("[TB] FAIL q_c_done got %b want 1", note_done); end
    tick = 1'b1; cycle(); tick = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL q_busy_end got %b want 0", busy); end
  endtask

  task automatic test_coincide();
    cmd_valid = 1'b1; cmd_period = 16'd1; cmd_len = 8'd1;
    cycle();
    cmd_valid = 1'b0;
    cycle();
    cycle();
    checks++; if (audio_out !== 1'b0) begin errors++; $display("[TB] FAIL co_audio1 got %b want 0", audio_out); end
    tick = 1'b1; cycle(); tick = 1'b0;
    checks++; if (audio_out !== 1'b0) begin errors++; $display("[TB] FAIL co_audio2 got %b want 0", audio_out); end
    checks++; if (note_done !== 1'b1) begin errors++; $display("[TB] FAIL co_done got %b want 1", note_done); end
    cycle();
    checks++; if (audio_out !== 1'b0) begin errors++; $display("[TB] FAIL co_audio3 got %b want 0", audio_out); end
    checks++; if (note_done !== 1'b0) begin errors++; $display("[TB] FAIL co_done_once got %b want 0", note_done); end
    tick = 1'b1; cycle(); tick = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL co_busy_end got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_play();
    cmd_valid = 1'b1; cmd_period = 16'd1; cmd_len = 8'd5;
    cycle();
    cmd_valid = 1'b0;
    cycle();
    cmd_valid = 1'b1; cmd_period = 16'd4; cmd_len = 8'd2;
    cycle();
    cmd_valid = 1'b0;
    cycle();
    checks++; if (audio_out !== 1'b1) begin errors++; $display("[TB] FAIL rm_audio_pre got %b want 1", audio_out); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL rm_ready_pre got %b want 0", cmd_ready); end
    reset = 1'b1;
    cycle();
    checks++; if (audio_out !== 1'b0) begin errors++; $display("[TB] FAIL rm_audio got %b want 0", audio_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rm_busy got %b want 0", busy); end
    checks++; if (note_done !== 1'b0) begin errors++; $display("[TB] FAIL rm_done got %b want 0", note_done); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL rm_ready_held got %b want 0", cmd_ready); end
    reset = 1'b0;
    cycle();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_ready_rel got %b want 1", cmd_ready); end
    checks++; if (note_done !== 1'b0) begin errors++; $display("[TB] FAIL rm_done_rel got %b want 0", note_done); end
    cycle();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rm_busy_rel got %b want 0", busy); end
    checks++; if (audio_out !== 1'b0) begin errors++; $display("[TB] FAIL rm_audio_rel got %b want 0", audio_out); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; tick = 1'b0; cmd_valid = 1'b0; cmd_period = '0; cmd_len = '0;
    test_reset();
    test_tone();
    test_rest();
    test_len_zero_one();
    test_back_to_back();
    test_coincide();
    test_reset_mid_play();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
